// File: rtl/rev_count_seq_if.sv
// Command/status bundle between a command source and the rev_count_seq sequencer.
// master: command source side; slave: sequencer side.
interface rev_count_seq_if #(
    parameter int WIDTH = 16,
    parameter int LAPW  = 8
);
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             tick;
    logic             abort;
    logic [WIDTH-1:0] cnt;
    logic             S;
    logic             Rc;
    logic             busy;
    logic             done;
    logic             err;
    logic [LAPW-1:0]  laps;

    modport master (
        output start, dir, lo, hi, tick, abort,
        input  cnt, S, Rc, busy, done, err, laps
    );

    modport slave (
        input  start, dir, lo, hi, tick, abort,
        output cnt, S, Rc, busy, done, err, laps
    );
endinterface

// File: rtl/rev_count_seq.sv
// Sequencer for the reversible up/down counter datapath.
// Optional feature macro: REV_PINGPONG_EN -- when defined, hitting a limit on a
// tick reverses direction and counts laps instead of ending the run.
//
// state | meaning
// IDLE  | waiting for start; cnt/S/err/laps hold from the previous run
// LOAD  | one cycle: counter loaded with the start value for the direction
// RUN   | stepping on tick until a limit (or abort)
// DONE  | one-cycle done pulse, then back to IDLE
module rev_count_seq #(
    parameter int WIDTH = 16,
    parameter int LAPW  = 8
) (
    input logic           clk,
    input logic           rst,
    rev_count_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_r, lo_r, hi_r;
    logic             s_r, err_r;
    logic             rc, busy, done;
    logic             bad_lim;
    logic             limit_tick;

    assign bad_lim    = bus.lo > bus.hi;
    assign limit_tick = bus.tick && rc && !bus.abort;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; abort has priority over the limit, which beats a step.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = bad_lim ? DONE : LOAD;
            LOAD: state_nxt = RUN;
            RUN: begin
                if (bus.abort) begin
                    state_nxt = DONE;
                end else if (bus.tick && rc) begin
`ifdef REV_PINGPONG_EN
                    state_nxt = RUN;
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state; Rc compares against the active limit.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        rc   = 1'b0;
        unique case (state)
            LOAD: busy = 1'b1;
            RUN: begin
                busy = 1'b1;
                rc   = cnt_r == (s_r ? hi_r : lo_r);
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Counter, direction, latched limits and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            lo_r  <= '0;
            hi_r  <= '0;
            s_r   <= 1'b0;
            err_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        lo_r  <= bus.lo;
                        hi_r  <= bus.hi;
                        s_r   <= bus.dir;
                        err_r <= bad_lim;
                    end
                end
                LOAD: cnt_r <= s_r ? lo_r : hi_r;
                RUN: begin
                    if (!bus.abort && bus.tick && !rc)
                        cnt_r <= s_r ? cnt_r + WIDTH'(1) : cnt_r - WIDTH'(1);
`ifdef REV_PINGPONG_EN
                    if (limit_tick) s_r <= ~s_r;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef REV_PINGPONG_EN
    logic [LAPW-1:0] laps_r;

    // Lap counter: cleared by an accepted start, bumped on each reversal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           laps_r <= '0;
        else if (state == IDLE && bus.start) laps_r <= '0;
        else if (state == RUN && limit_tick) laps_r <= laps_r + LAPW'(1);
    end

    assign bus.laps = laps_r;
`else
    assign bus.laps = '0;
`endif

    assign bus.cnt  = cnt_r;
    assign bus.S    = s_r;
    assign bus.Rc   = rc;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_rev_count_seq.sv
// Directed self-checking bench for rev_count_seq; covers both builds of REV_PINGPONG_EN.
module tb_rev_count_seq;
    localparam int WIDTH = 16;
    localparam int LAPW  = 8;

    logic clk;
    logic rst;
    int   n_test;
    int   n_fail;

    rev_count_seq_if #(.WIDTH(WIDTH), .LAPW(LAPW)) bus ();

    rev_count_seq #(.WIDTH(WIDTH), .LAPW(LAPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_test++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmd(input logic [15:0] l, input logic [15:0] h, input logic d);
        bus.lo    = l;
        bus.hi    = h;
        bus.dir   = d;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, ".cnt"},  32'(bus.cnt),  32'h0);
        check({tag, ".S"},    32'(bus.S),    32'h0);
        check({tag, ".busy"}, 32'(bus.busy), 32'h0);
        check({tag, ".done"}, 32'(bus.done), 32'h0);
        check({tag, ".err"},  32'(bus.err),  32'h0);
        check({tag, ".Rc"},   32'(bus.Rc),   32'h0);
        check({tag, ".laps"}, 32'(bus.laps), 32'h0);
    endtask

    initial begin
        logic [15:0] pp_cnt [8];
        logic        pp_s   [8];
        logic [7:0]  pp_laps[8];

        n_test = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.dir = 1'b0; bus.lo = '0; bus.hi = '0;
        bus.tick  = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        cyc();

        // Up run 3..6 with tick held high.
        cmd(16'h0003, 16'h0006, 1'b1);
        check("up.busy_load", 32'(bus.busy), 32'h1);
        check("up.S_load",    32'(bus.S),    32'h1);
        check("up.cnt_load",  32'(bus.cnt),  32'h0);
        bus.tick = 1'b1;
        cyc();
        check("up.cnt3", 32'(bus.cnt), 32'h3);
        check("up.rc3",  32'(bus.Rc),  32'h0);
        cyc(); check("up.cnt4", 32'(bus.cnt), 32'h4);
        cyc(); check("up.cnt5", 32'(bus.cnt), 32'h5);
        cyc(); check("up.cnt6", 32'(bus.cnt), 32'h6);
        check("up.rc6", 32'(bus.Rc), 32'h1);
        cyc();
`ifdef REV_PINGPONG_EN
        check("up.rev_S",    32'(bus.S),    32'h0);
        check("up.rev_cnt",  32'(bus.cnt),  32'h6);
        check("up.rev_laps", 32'(bus.laps), 32'h1);
        bus.tick = 1'b0;
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
`endif
        check("up.done",  32'(bus.done), 32'h1);
        check("up.busy0", 32'(bus.busy), 32'h0);
        check("up.cntf",  32'(bus.cnt),  32'h6);
        check("up.err",   32'(bus.err),  32'h0);
        bus.tick = 1'b0;
        cyc();
        check("up.done_off", 32'(bus.done), 32'h0);

        // Down run with gapped ticks, an ignored start, then abort.
        cmd(16'h0000, 16'hFFFF, 1'b0);
        cyc();
        check("dn.cnt_ffff", 32'(bus.cnt), 32'hFFFF);
        check("dn.rc",       32'(bus.Rc),  32'h0);
        bus.tick = 1'b1; cyc(); check("dn.fffe",  32'(bus.cnt), 32'hFFFE);
        bus.tick = 1'b0; cyc(); check("dn.hold1", 32'(bus.cnt), 32'hFFFE);
        bus.tick = 1'b1; cyc(); check("dn.fffd",  32'(bus.cnt), 32'hFFFD);
        bus.tick = 1'b0;
        cmd(16'h0010, 16'h0020, 1'b1);
        check("dn.ign_cnt",  32'(bus.cnt),  32'hFFFD);
        check("dn.ign_S",    32'(bus.S),    32'h0);
        check("dn.ign_busy", 32'(bus.busy), 32'h1);
        bus.abort = 1'b1; bus.tick = 1'b1;
        cyc();
        bus.abort = 1'b0; bus.tick = 1'b0;
        check("dn.abort_done", 32'(bus.done), 32'h1);
        check("dn.abort_cnt",  32'(bus.cnt),  32'hFFFD);
        cyc();

        // Limit error path; tick/abort ignored in IDLE.
        cmd(16'h0010, 16'h000F, 1'b1);
        check("err.done", 32'(bus.done), 32'h1);
        check("err.err",  32'(bus.err),  32'h1);
        check("err.busy", 32'(bus.busy), 32'h0);
        check("err.cnt",  32'(bus.cnt),  32'hFFFD);
        bus.tick = 1'b1;
        cyc();
        check("err.idle_done", 32'(bus.done), 32'h0);
        check("err.sticky",    32'(bus.err),  32'h1);
        check("err.idle_cnt",  32'(bus.cnt),  32'hFFFD);
        bus.tick = 1'b0;

        // Degenerate limits lo == hi.
        cmd(16'h0007, 16'h0007, 1'b1);
        check("deg.err_clr", 32'(bus.err), 32'h0);
        cyc();
        check("deg.cnt", 32'(bus.cnt), 32'h7);
        check("deg.rc",  32'(bus.Rc),  32'h1);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
`ifdef REV_PINGPONG_EN
        check("deg.S",    32'(bus.S),    32'h0);
        check("deg.cnt2", 32'(bus.cnt),  32'h7);
        check("deg.laps", 32'(bus.laps), 32'h1);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
`endif
        check("deg.done", 32'(bus.done), 32'h1);
        check("deg.cntf", 32'(bus.cnt),  32'h7);
        cyc();

`ifdef REV_PINGPONG_EN
        // Ping-pong between 1 and 3.
        pp_cnt  = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd2, 16'd1, 16'd1, 16'd2};
        pp_s    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        pp_laps = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
        cmd(16'h0001, 16'h0003, 1'b1);
        bus.tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check($sformatf("pp.cnt%0d", i),  32'(bus.cnt),  32'(pp_cnt[i]));
            check($sformatf("pp.S%0d", i),    32'(bus.S),    32'(pp_s[i]));
            check($sformatf("pp.laps%0d", i), 32'(bus.laps), 32'(pp_laps[i]));
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0; bus.tick = 1'b0;
        check("pp.done", 32'(bus.done), 32'h1);
        cyc();
`else
        pp_cnt[0] = '0; pp_s[0] = 1'b0; pp_laps[0] = '0;
        check("nomac.laps", 32'(bus.laps), 32'(pp_laps[0]));
`endif

        // Asynchronous reset in the middle of a run at cnt = 5.
        cmd(16'h0000, 16'h0010, 1'b1);
        bus.tick = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        bus.tick = 1'b0;
        check("mid.cnt5", 32'(bus.cnt),  32'h5);
        check("mid.busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        #1;
        chk_reset_vals("mid");
        @(negedge clk);
        rst = 1'b0;
        cmd(16'h0002, 16'h0004, 1'b0);
        check("post.busy", 32'(bus.busy), 32'h1);
        cyc();
        check("post.cnt", 32'(bus.cnt), 32'h4);
        check("post.S",   32'(bus.S),   32'h0);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule
